// File: rtl/memory_access_stage.sv
// Memory stage of the RV32I pipeline: registers Execute results, runs loads and
// stores over a valid/ready data-memory handshake, and stalls while an access is outstanding.
module memory_access_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ALU_result_E,
    input  logic [31:0] write_data_E,
    input  logic [4:0]  rd_E,
    input  logic        reg_write_E,
    input  logic        mem_read_E,
    input  logic        mem_write_E,
    input  logic [2:0]  funct3_E,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] ALU_result_M,
    output logic [4:0]  rd_M,
    output logic        reg_write_M,
    output logic        mem_read_M,
    output logic [31:0] load_data_M,
    output logic        mem_fault_M,
    output logic        stall_M
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t      state, state_next;
    logic [31:0] write_data_m;
    logic        reg_write_r;
    logic        mem_write_m;
    logic [2:0]  funct3_m;
    logic        mem_op;
    logic        fault;
    logic        busy;
    logic [1:0]  byte_off;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    assign mem_op   = mem_read_M | mem_write_m;
    assign byte_off = ALU_result_M[1:0];
    assign busy     = mem_op & ~fault;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ALU_result_M <= '0;
            write_data_m <= '0;
            rd_M         <= '0;
            reg_write_r  <= 1'b0;
            mem_read_M   <= 1'b0;
            mem_write_m  <= 1'b0;
            funct3_m     <= '0;
        end else if (!stall_M) begin
            ALU_result_M <= ALU_result_E;
            write_data_m <= write_data_E;
            rd_M         <= rd_E;
            reg_write_r  <= reg_write_E;
            mem_read_M   <= mem_read_E;
            mem_write_m  <= mem_write_E;
            funct3_m     <= funct3_E;
        end
    end

    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    always_comb begin
        fault = 1'b0;
        case (funct3_m)
            3'b000, 3'b100: fault = 1'b0;
            3'b001, 3'b101: fault = byte_off[0];
            3'b010:         fault = |byte_off;
            default:        fault = 1'b1;
        endcase
        if (!mem_op) fault = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        stall_M    = 1'b0;
        dmem_req   = 1'b0;
        case (state)
            IDLE: if (busy) state_next = dmem_ready ? DONE : WAIT;
            WAIT: if (dmem_ready) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // DONE releases the stall so the next instruction enters on the same edge.
        if (busy && state != DONE) begin
            stall_M  = 1'b1;
            dmem_req = 1'b1;
        end
    end

    assign mem_fault_M = fault;
    assign reg_write_M = reg_write_r & ~fault;
    assign dmem_we     = mem_write_m;
    assign dmem_addr   = {ALU_result_M[31:2], 2'b00};

    always_comb begin
        dmem_wdata = write_data_m;
        dmem_wstrb = 4'b0000;
        case (funct3_m[1:0])
            2'b00: begin
                dmem_wdata = {4{write_data_m[7:0]}};
                dmem_wstrb = 4'b0001 << byte_off;
            end
            2'b01: begin
                dmem_wdata = {2{write_data_m[15:0]}};
                dmem_wstrb = byte_off[1] ? 4'b1100 : 4'b0011;
            end
            default: dmem_wstrb = 4'b1111;
        endcase
        if (!mem_write_m || fault) dmem_wstrb = 4'b0000;
    end

    always_comb begin
        ld_byte = dmem_rdata[{byte_off, 3'b000} +: 8];
        ld_half = byte_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (funct3_m)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_ext = {24'b0, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_ext = {16'b0, ld_half};
            default: ld_ext = dmem_rdata;
        endcase
    end

    // A load with the store flag also set is a store, so it never captures.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            load_data_M <= '0;
        else if (dmem_req && dmem_ready && !mem_write_m)
            load_data_M <= ld_ext;
    end

endmodule

// File: tb/tb_memory_access_stage.sv
// Randomized bench for memory_access_stage: each instruction is followed through M
// and compared cycle by cycle with a reference model built from the access rules.
module tb_memory_access_stage;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] wd;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic [2:0]  f3;
    } instr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ALU_result_E, write_data_E;
    logic [4:0]  rd_E;
    logic        reg_write_E, mem_read_E, mem_write_E;
    logic [2:0]  funct3_E;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic [31:0] ALU_result_M;
    logic [4:0]  rd_M;
    logic        reg_write_M, mem_read_M;
    logic [31:0] load_data_M;
    logic        mem_fault_M, stall_M;

    int checks = 0;
    int failures = 0;
    logic [31:0] last_load = 32'h0;

    always #5 clk = ~clk;

    memory_access_stage dut (
        .clk(clk), .rst(rst),
        .ALU_result_E(ALU_result_E), .write_data_E(write_data_E), .rd_E(rd_E),
        .reg_write_E(reg_write_E), .mem_read_E(mem_read_E), .mem_write_E(mem_write_E),
        .funct3_E(funct3_E),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .ALU_result_M(ALU_result_M), .rd_M(rd_M), .reg_write_M(reg_write_M),
        .mem_read_M(mem_read_M), .load_data_M(load_data_M),
        .mem_fault_M(mem_fault_M), .stall_M(stall_M)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic instr_t mk(input logic [31:0] alu, input logic [31:0] wd,
                                  input logic mr, input logic mw, input logic [2:0] f3);
        instr_t i;
        i.alu = alu; i.wd = wd; i.rd = 5'd7; i.rw = mr; i.mr = mr; i.mw = mw; i.f3 = f3;
        return i;
    endfunction

    function automatic instr_t rand_instr();
        instr_t i;
        int k;
        logic [2:0] legal [5];
        legal = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        k = int'($urandom_range(0, 3));
        i.alu = $urandom;
        if ($urandom_range(0, 2) != 0) i.alu[1:0] = 2'b00;
        i.wd = $urandom;
        i.rd = 5'($urandom);
        i.rw = 1'($urandom);
        i.mr = (k == 1) || (k == 3);
        i.mw = (k == 2) || (k == 3);
        if ($urandom_range(0, 4) != 0) i.f3 = legal[$urandom_range(0, 4)];
        else                           i.f3 = 3'($urandom);
        return i;
    endfunction

    function automatic int size_of(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic logic exp_fault(input instr_t i);
        int sz;
        sz = size_of(i.f3);
        if (!(i.mr || i.mw)) return 1'b0;
        if (sz == 0) return 1'b1;
        return (i.alu % sz) != 0;
    endfunction

    function automatic logic [31:0] exp_wdata(input instr_t i);
        case (size_of(i.f3))
            1:       return (i.wd & 32'hFF) * 32'h0101_0101;
            2:       return (i.wd & 32'hFFFF) * 32'h0001_0001;
            default: return i.wd;
        endcase
    endfunction

    function automatic logic [31:0] exp_wstrb(input instr_t i);
        int sz;
        sz = size_of(i.f3);
        return ((32'd1 << sz) - 32'd1) << (i.alu % 4);
    endfunction

    function automatic logic [31:0] exp_load(input instr_t i, input logic [31:0] rdata);
        logic [31:0] sh;
        sh = rdata >> (8 * (i.alu % 4));
        case (i.f3)
            3'b000:  return {{24{sh[7]}}, sh[7:0]};
            3'b100:  return {24'b0, sh[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b101:  return {16'b0, sh[15:0]};
            default: return rdata;
        endcase
    endfunction

    task automatic drive_e(input instr_t i);
        ALU_result_E = i.alu;
        write_data_E = i.wd;
        rd_E         = i.rd;
        reg_write_E  = i.rw;
        mem_read_E   = i.mr;
        mem_write_E  = i.mw;
        funct3_E     = i.f3;
    endtask

    // Entered at a negedge where the current M instruction is in its last cycle;
    // returns at the negedge of this instruction's last cycle in M.
    task automatic do_instr(input instr_t ins, input int waits, input logic [31:0] rdata);
        logic flt;
        flt = exp_fault(ins);
        drive_e(ins);
        @(negedge clk);
        check("alu_m", ALU_result_M, ins.alu);
        check("rd_m", 32'(rd_M), 32'(ins.rd));
        check("mem_read_m", 32'(mem_read_M), 32'(ins.mr));
        check("fault", 32'(mem_fault_M), 32'(flt));
        check("reg_write_m", 32'(reg_write_M), 32'(ins.rw & ~flt));
        if (!(ins.mr || ins.mw) || flt) begin
            check("stall_1cyc", 32'(stall_M), 32'd0);
            check("req_1cyc", 32'(dmem_req), 32'd0);
            check("load_hold", load_data_M, last_load);
            dmem_ready = 1'($urandom);
            dmem_rdata = $urandom;
        end else begin
            for (int c = 0; c <= waits; c++) begin
                if (c > 0) begin
                    @(negedge clk);
                    check("alu_hold", ALU_result_M, ins.alu);
                end
                check("req", 32'(dmem_req), 32'd1);
                check("stall", 32'(stall_M), 32'd1);
                check("addr", dmem_addr, ins.alu & 32'hFFFF_FFFC);
                check("we", 32'(dmem_we), 32'(ins.mw));
                if (ins.mw) begin
                    check("wdata", dmem_wdata, exp_wdata(ins));
                    check("wstrb", 32'(dmem_wstrb), exp_wstrb(ins));
                end else begin
                    check("wstrb_ld", 32'(dmem_wstrb), 32'd0);
                end
                dmem_ready = (c == waits);
                dmem_rdata = (c == waits) ? rdata : $urandom;
                drive_e(rand_instr());
            end
            @(negedge clk);
            check("done_req", 32'(dmem_req), 32'd0);
            check("done_stall", 32'(stall_M), 32'd0);
            check("done_alu", ALU_result_M, ins.alu);
            if (ins.mr && !ins.mw) last_load = exp_load(ins, rdata);
            check("load_data", load_data_M, last_load);
            dmem_ready = 1'($urandom);
            dmem_rdata = $urandom;
        end
    endtask

    initial begin
        rst = 1'b1;
        dmem_ready = 1'b0;
        dmem_rdata = 32'h0;
        drive_e(mk(32'h0, 32'h0, 1'b0, 1'b0, 3'b000));
        @(negedge clk);
        @(negedge clk);
        check("rst_req", 32'(dmem_req), 32'd0);
        check("rst_stall", 32'(stall_M), 32'd0);
        check("rst_fault", 32'(mem_fault_M), 32'd0);
        check("rst_wstrb", 32'(dmem_wstrb), 32'd0);
        check("rst_alu", ALU_result_M, 32'd0);
        check("rst_rd", 32'(rd_M), 32'd0);
        check("rst_regw", 32'(reg_write_M), 32'd0);
        check("rst_mrd", 32'(mem_read_M), 32'd0);
        check("rst_load", load_data_M, 32'd0);
        rst = 1'b0;

        do_instr(mk(32'h0000_0011, 32'h0, 1'b0, 1'b0, 3'b000), 0, 32'h0);
        do_instr(mk(32'h0000_0100, 32'hDEAD_BEEF, 1'b0, 1'b1, 3'b010), 3, 32'h0);
        do_instr(mk(32'h0000_0103, 32'h0000_00A5, 1'b0, 1'b1, 3'b000), 0, 32'h0);
        do_instr(mk(32'h0000_0202, 32'h0, 1'b1, 1'b0, 3'b000), 1, 32'h12F4_5678);
        check("lb_value", load_data_M, 32'hFFFF_FFF4);
        do_instr(mk(32'h0000_0202, 32'h0, 1'b1, 1'b0, 3'b101), 0, 32'h12F4_5678);
        check("lhu_value", load_data_M, 32'h0000_12F4);
        do_instr(mk(32'h0000_0101, 32'h0, 1'b1, 1'b0, 3'b010), 0, 32'h0);
        do_instr(mk(32'h0000_0AA0, 32'h0, 1'b0, 1'b0, 3'b000), 0, 32'h0);
        do_instr(mk(32'h0000_0400, 32'h0, 1'b1, 1'b0, 3'b010), 0, 32'hCAFE_F00D);
        do_instr(mk(32'h0000_0BB0, 32'h0, 1'b0, 1'b0, 3'b000), 0, 32'h0);

        // Reset asserted while the request is waiting must drop it at once.
        drive_e(mk(32'h0000_0300, 32'h1234_5678, 1'b0, 1'b1, 3'b010));
        dmem_ready = 1'b0;
        @(negedge clk);
        check("pre_rst_req", 32'(dmem_req), 32'd1);
        dmem_ready = 1'b0;
        @(negedge clk);
        check("wait_req", 32'(dmem_req), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_req", 32'(dmem_req), 32'd0);
        check("mid_rst_stall", 32'(stall_M), 32'd0);
        check("mid_rst_alu", ALU_result_M, 32'd0);
        check("mid_rst_wstrb", 32'(dmem_wstrb), 32'd0);
        check("mid_rst_load", load_data_M, 32'd0);
        check("mid_rst_fault", 32'(mem_fault_M), 32'd0);
        drive_e(mk(32'h0, 32'h0, 1'b0, 1'b0, 3'b000));
        @(negedge clk);
        rst = 1'b0;
        last_load = 32'h0;

        for (int n = 0; n < 200; n++)
            do_instr(rand_instr(), int'($urandom_range(0, 3)), $urandom);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/memory_access_stage.md
# memory_access_stage

Memory (M) stage of the five-stage RV32I pipeline, directly downstream of the Execute stage. It registers the Execute results (ALU result, forwarded store data, destination and control), runs loads and stores against the data memory over a valid/ready handshake, and stalls the pipeline while an access is outstanding. It aligns store data and byte strobes, and sign- or zero-extends load data. `ALU_result_M` also feeds the Execute-stage forwarding mux.

## Interface
Parameters:
- none; the design is fixed at XLEN=32 with 5-bit register indices.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `ALU_result_E` in 32: Execute ALU result (address for loads and stores).
- `write_data_E` in 32: forwarded rs2 value, used as store data.
- `rd_E` in 5: destination register.
- `reg_write_E` in 1: instruction writes rd.
- `mem_read_E` in 1: instruction is a load.
- `mem_write_E` in 1: instruction is a store.
- `funct3_E` in 3: access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `dmem_req` out 1: request valid.
- `dmem_we` out 1: 1 = store.
- `dmem_addr` out 32: word-aligned address, {`ALU_result_M`[31:2], 2'b00}.
- `dmem_wdata` out 32: lane-replicated store data.
- `dmem_wstrb` out 4: byte strobes; 0 for loads.
- `dmem_ready` in 1: memory accepts and completes the request this cycle.
- `dmem_rdata` in 32: read word; valid in the cycle `dmem_ready`=1.
- `ALU_result_M` out 32: registered ALU result.
- `rd_M` out 5: registered destination register.
- `reg_write_M` out 1: registered write enable, forced 0 when `mem_fault_M`=1.
- `mem_read_M` out 1: registered load flag.
- `load_data_M` out 32: extended load result, registered.
- `mem_fault_M` out 1: misaligned or illegal access in M.
- `stall_M` out 1: hold the F/D/E stages and this stage's input register.

## Operation
- Input register: captures all `_E` inputs on each edge where `stall_M`=0. It holds when `stall_M`=1.
- `mem_op` = `mem_read_M` | `mem_write_M`. If both are 1, treat it as a store.
- Fault detection (combinational on M register):
  - W requires addr[1:0]=00.
  - H/HU requires addr[0]=0.
  - funct3 ∈ {011, 110, 111} with `mem_op` is illegal.
  - A fault gives `mem_fault_M`=1, no request, `stall_M`=0, `reg_write_M`=0. The instruction passes in one cycle.
- FSM states: IDLE, WAIT, DONE.
  - IDLE: if `mem_op` and no fault, `dmem_req`=1. With `dmem_ready`=1, go to DONE; otherwise go to WAIT.
  - WAIT: `dmem_req`=1; on `dmem_ready`=1 go to DONE.
  - DONE: `dmem_req`=0, `stall_M`=0, and the next edge returns to IDLE. The M register loads the next instruction on that same edge.
- `stall_M` = `mem_op` & ~fault & (state ≠ DONE).
- Store lanes:
  - SB: wdata = {4{data[7:0]}}, wstrb = 0001 << addr[1:0].
  - SH: wdata = {2{data[15:0]}}, wstrb = addr[1] ? 1100 : 0011.
  - SW: wdata = data, wstrb = 1111.
- Load extract: `load_data_M` captures on the edge where `dmem_ready`=1 and a load is in progress.
  - B/BU select byte addr[1:0]; H/HU select half addr[1].
  - B and H sign-extend; BU and HU zero-extend; W passes the word through.
- Non-memory instructions: `stall_M`=0, the FSM stays in IDLE, and `load_data_M` holds its previous value.
- `dmem_ready` while `dmem_req`=0 is ignored.

## Timing
- Reset values: all M-register outputs 0, `load_data_M`=0, state IDLE, `dmem_req`=0, `stall_M`=0, `mem_fault_M`=0, `dmem_wstrb`=0.
- Reset mid-access: state returns to IDLE and `dmem_req` drops immediately (asynchronous). The pending access is abandoned.
- Request stability: `dmem_addr`, `dmem_we`, `dmem_wdata` and `dmem_wstrb` are constant from `dmem_req` rising until the `dmem_ready` cycle.
- Memory op with zero wait: 2 cycles in M (request+ready, then DONE).
- Memory op with N wait cycles: 2+N cycles in M.
- Non-memory or faulting op: 1 cycle in M.
- `load_data_M` is valid from the DONE cycle until the next load completes.
- `ALU_result_M` is valid one cycle after capture and is unaffected by stalls.

## Test plan
- Reset during WAIT with `dmem_req`=1 → `dmem_req`=0 immediately; state IDLE; all outputs 0.
- SW addr 0x100, data 0xDEADBEEF, `dmem_ready` delayed 3 cycles → `dmem_wstrb`=1111 and stable request for 4 cycles; `stall_M` high 4 cycles, then DONE.
- SB addr 0x103, data 0x000000A5, ready immediate → `dmem_wdata`=0xA5A5A5A5, `dmem_wstrb`=1000; 2 cycles in M.
- LB addr 0x202, rdata 0x12F45678 → `load_data_M`=0xFFFFFFF4. LHU addr 0x202 with the same rdata → 0x000012F4.
- LW addr 0x101 → `mem_fault_M`=1, `dmem_req`=0, `reg_write_M`=0, `stall_M`=0; next instruction enters M on the next edge.
- Back-to-back ALU op, LW (ready immediate), ALU op → ALU ops take 1 cycle each, LW takes 2. `ALU_result_M` tracks each instruction with no duplication or loss.
